// File: rtl/bist_stimulus_misr.sv
// BIST stimulus and response compaction for the 6:3 counter CUT: an LFSR drives
// pseudo-random patterns, a MISR folds the responses, and the signature is strobed out.
module bist_stimulus_misr #(
    parameter int unsigned       PAT_W        = 6,
    parameter int unsigned       SIG_W        = 3,
    parameter int unsigned       NUM_PATTERNS = 7,
    parameter logic [PAT_W-1:0]  LFSR_SEED    = 6'b000001,
    parameter logic [PAT_W-1:0]  LFSR_TAPS    = 6'b110000,
    parameter logic [SIG_W-1:0]  MISR_SEED    = 3'b000,
    parameter logic [SIG_W-1:0]  MISR_POLY    = 3'b011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             tm,
    output logic [PAT_W-1:0] cut_in,
    input  logic [SIG_W-1:0] cut_out,
    output logic [SIG_W-1:0] sig,
    output logic             sig_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(NUM_PATTERNS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [PAT_W-1:0] lfsr_q, lfsr_d;
    logic [SIG_W-1:0] misr_q, misr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [SIG_W-1:0] sig_q;
    logic             tm_q, sig_valid_q, busy_q, done_q;

    // Next LFSR pattern (Fibonacci) and next MISR value (Galois shift, then fold in the response).
    always_comb begin
        lfsr_d = {lfsr_q[PAT_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        misr_d = {misr_q[SIG_W-2:0], 1'b0}
               ^ (misr_q[SIG_W-1] ? MISR_POLY : '0)
               ^ cut_out;
    end

    // NOTE: reset is sampled on the clock edge and beats every other input, including start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_SEED;
            misr_q      <= MISR_SEED;
            cnt_q       <= '0;
            sig_q       <= '0;
            tm_q        <= 1'b0;
            sig_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: all state updates are non-blocking so every branch sees the pre-edge values.
            case (state_q)
                S_IDLE: begin
                    sig_valid_q <= 1'b0;
                    if (start) begin
                        lfsr_q  <= LFSR_SEED;
                        misr_q  <= MISR_SEED;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        tm_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    misr_q <= misr_d;
                    lfsr_q <= lfsr_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    // Last absorb: the signature register takes the final MISR value directly.
                    if (cnt_q == LAST_CNT) begin
                        sig_q       <= misr_d;
                        sig_valid_q <= 1'b1;
                        done_q      <= 1'b1;
                        tm_q        <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    sig_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    sig_valid_q <= 1'b0;
                    tm_q        <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign tm        = tm_q;
    assign cut_in    = lfsr_q;
    assign sig       = sig_q;
    assign sig_valid = sig_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bist_stimulus_misr.sv
// Bench for bist_stimulus_misr: a table-driven CUT and an arithmetic model of the
// pattern sequence and GF(2) signature folding.
module tb_bist_stimulus_misr;

    localparam int PAT_W = 6;
    localparam int SIG_W = 3;
    localparam int N     = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             tm;
    logic [PAT_W-1:0] cut_in;
    logic [SIG_W-1:0] cut_out;
    logic [SIG_W-1:0] sig;
    logic             sig_valid;
    logic             busy;
    logic             done;

    logic [SIG_W-1:0] lut [64];
    assign cut_out = lut[cut_in];

    int n_cmp = 0;
    int n_err = 0;

    int        exp_pats [$];
    int        exp_sig;

    always #5 clk = ~clk;

    bist_stimulus_misr dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tm        (tm),
        .cut_in    (cut_in),
        .cut_out   (cut_out),
        .sig       (sig),
        .sig_valid (sig_valid),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input int observed, input int expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CUT response tables: 0 = popcount, 1 = stuck-at-zero, 2 = random function.
    task automatic load_cut(input int mode);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0:       lut[i] = 3'($countones(6'(i)));
                1:       lut[i] = 3'd0;
                default: lut[i] = 3'($urandom_range(7, 0));
            endcase
        end
    endtask

    // Patterns as integer shift with parity feedback of x^6 and x^5 terms; signature as
    // repeated multiply-by-x modulo x^3+x+1 plus the response.
    task automatic build_expected();
        int x;
        int m;
        exp_pats.delete();
        x = 1;
        m = 0;
        for (int k = 0; k < N; k++) begin
            exp_pats.push_back(x);
            m = m * 2;
            if (m >= 8) m = m ^ 11;
            m = m ^ int'(lut[x]);
            x = ((x * 2) % 64) | (((x / 32) ^ (x / 16)) & 1);
        end
        exp_sig = m;
    endtask

    // One complete run from IDLE; optional start pulses in RUN cycle 3 and in DONE.
    task automatic do_run(input string tag, input bit pulse_start);
        build_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy_run"}, int'(busy), 1);
        check({tag, " done_clr"}, int'(done), 0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s cut_in[%0d]", tag, i), int'(cut_in), exp_pats[i]);
            check($sformatf("%s tm[%0d]", tag, i), int'(tm), 1);
            check($sformatf("%s nosv[%0d]", tag, i), int'(sig_valid), 0);
            if (pulse_start && i == 2) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check({tag, " sig_valid"}, int'(sig_valid), 1);
        check({tag, " sig"}, int'(sig), exp_sig);
        check({tag, " done"}, int'(done), 1);
        check({tag, " tm_done"}, int'(tm), 0);
        check({tag, " busy_done"}, int'(busy), 1);
        if (pulse_start) start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " sv_drop"}, int'(sig_valid), 0);
        check({tag, " done_hold"}, int'(done), 1);
        check({tag, " sig_hold"}, int'(sig), exp_sig);
        check({tag, " busy_idle"}, int'(busy), 0);
        tick();
        check({tag, " stay_idle"}, int'(busy), 0);
        check({tag, " no_2nd_sv"}, int'(sig_valid), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        load_cut(0);
        tick();
        tick();
        reset = 1'b0;
        check("rst tm", int'(tm), 0);
        check("rst sig", int'(sig), 0);
        check("rst sig_valid", int'(sig_valid), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst cut_in", int'(cut_in), 1);

        // Popcount CUT: golden signature is 3'b101.
        do_run("nominal", 1'b0);
        check("nominal golden", exp_sig, 5);

        load_cut(1);
        do_run("stuck0", 1'b0);
        check("stuck0 golden", int'(sig), 0);

        load_cut(0);
        do_run("ignored_start", 1'b0 | 1'b1);

        // Reset during RUN cycle 4 aborts with no strobe and clears the signature.
        build_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("abort busy_pre", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort tm", int'(tm), 0);
        check("abort busy", int'(busy), 0);
        check("abort sig", int'(sig), 0);
        check("abort done", int'(done), 0);
        check("abort cut_in", int'(cut_in), 1);
        for (int i = 0; i < N + 2; i++) begin
            check($sformatf("abort nosv[%0d]", i), int'(sig_valid), 0);
            tick();
        end
        do_run("after_abort", 1'b0);

        // start held high: back-to-back runs, a strobe every N+2 cycles.
        build_expected();
        start = 1'b1;
        for (int c = 0; c < 3 * (N + 2); c++) begin
            tick();
            check($sformatf("held sv[%0d]", c), int'(sig_valid), int'((c % (N + 2)) == N));
            check($sformatf("held busy[%0d]", c), int'(busy), int'((c % (N + 2)) != N + 1));
            check($sformatf("held tm[%0d]", c), int'(tm), int'((c % (N + 2)) < N));
            if ((c % (N + 2)) == N) check($sformatf("held sig[%0d]", c), int'(sig), exp_sig);
            if ((c % (N + 2)) == 0) check($sformatf("held done[%0d]", c), int'(done), 0);
        end
        start = 1'b0;
        tick();
        check("held end_idle", int'(busy), 0);

        // Random CUT functions with random idle gaps between runs.
        for (int r = 0; r < 4; r++) begin
            load_cut(2);
            repeat ($urandom_range(3, 0)) tick();
            do_run($sformatf("rand%0d", r), 1'($urandom_range(1, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
